// File: rtl/par_ser_pkg.sv
// Shared types and width helpers for the multi-lane serializer.
// Parameter-dependent widths are derived in the top via these functions.
package par_ser_pkg;

   typedef enum logic {
      SYNC   = 1'b0,
      ACTIVE = 1'b1
   } ser_state_e;

   function automatic int cnt_width(input int bpl);
      return (bpl < 2) ? 1 : $clog2(bpl);
   endfunction

   function automatic int sync_width(input int words);
      return (words < 1) ? 1 : $clog2(words + 1);
   endfunction

endpackage

// File: rtl/ser_fifo2.sv
// Two-entry word buffer between the handshake and the lane shifters.
// Head is valid whenever count is non-zero.
module ser_fifo2
   import par_ser_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_L,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic [1:0]   count
);

   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         wr_q, wr_d;
   logic         rd_q, rd_d;
   logic [1:0]   cnt_q, cnt_d;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push) begin
         mem_d[wr_q] = din;
         wr_d        = ~wr_q;
      end
      if (pop) begin
         rd_d = ~rd_q;
      end
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         mem_q <= '{default: '0};
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign head  = mem_q[rd_q];
   assign count = cnt_q;

endmodule

// File: rtl/par_serializer_lanes.sv
// Buffers parallel words and shifts them MSB-first over LANES serial lanes,
// with a sync preamble and idle fill of IDLE_WORD.
module par_serializer_lanes
   import par_ser_pkg::*;
#(
   parameter int                DATA_W     = 8,
   parameter int                LANES      = 1,
   parameter logic [DATA_W-1:0] IDLE_WORD  = 8'hBC,
   parameter int                SYNC_WORDS = 4
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] data_in,
   output logic              ready_out,
   output logic [LANES-1:0]  data_out,
   output logic              word_start,
   output logic              data_active,
   output logic              sync_done
);

   localparam int BPL    = DATA_W / LANES;
   localparam int CNT_W  = cnt_width(BPL);
   localparam int SYNC_W = sync_width(SYNC_WORDS);

   if (DATA_W % LANES != 0) begin : g_bad_lanes
      $error("DATA_W must be divisible by LANES");
   end
   if (SYNC_WORDS < 1) begin : g_bad_sync
      $error("SYNC_WORDS must be at least 1");
   end

   ser_state_e        state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              data_active_q, data_active_d;
   logic              sync_done_q, sync_done_d;

   logic [DATA_W-1:0] fifo_head;
   logic [1:0]        fifo_count;
   logic              slot_end;
   logic              push;
   logic              pop;

   assign slot_end  = (bit_cnt_q == CNT_W'(BPL - 1));
   assign ready_out = (state_q == ACTIVE) && (fifo_count < 2'd2);
   assign push      = valid_in && ready_out;
   // Pop sees the pre-edge count, so a same-edge push cannot be loaded.
   assign pop       = slot_end && (state_q == ACTIVE) && (fifo_count != 2'd0);

   ser_fifo2 #(
      .W(DATA_W)
   ) u_fifo (
      .clk    (clk),
      .reset_L(reset_L),
      .push   (push),
      .pop    (pop),
      .din    (data_in),
      .head   (fifo_head),
      .count  (fifo_count)
   );

   always_comb begin
      state_d       = state_q;
      sync_cnt_d    = sync_cnt_q;
      data_active_d = data_active_q;
      sync_done_d   = sync_done_q;
      bit_cnt_d     = slot_end ? '0 : bit_cnt_q + CNT_W'(1);
      shreg_d       = shreg_q;
      for (int l = 0; l < LANES; l++) begin
         for (int b = BPL - 1; b > 0; b--) begin
            shreg_d[l*BPL+b] = shreg_q[l*BPL+b-1];
         end
         shreg_d[l*BPL] = 1'b0;
      end
      if (slot_end) begin
         shreg_d       = pop ? fifo_head : IDLE_WORD;
         data_active_d = pop;
         if (state_q == SYNC) begin
            sync_cnt_d = sync_cnt_q + SYNC_W'(1);
            if (sync_cnt_q == SYNC_W'(SYNC_WORDS - 1)) begin
               state_d     = ACTIVE;
               sync_done_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q       <= SYNC;
         bit_cnt_q     <= '0;
         sync_cnt_q    <= '0;
         shreg_q       <= IDLE_WORD;
         data_active_q <= 1'b0;
         sync_done_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         sync_cnt_q    <= sync_cnt_d;
         shreg_q       <= shreg_d;
         data_active_q <= data_active_d;
         sync_done_q   <= sync_done_d;
      end
   end

   always_comb begin
      data_out = '0;
      for (int l = 0; l < LANES; l++) begin
         data_out[l] = shreg_q[l*BPL+BPL-1];
      end
   end

   assign word_start  = (bit_cnt_q == '0);
   assign data_active = data_active_q;
   assign sync_done   = sync_done_q;

endmodule

// File: tb/tb_par_serializer_lanes.sv
// Directed bench: one-lane and two-lane serializers sharing clock and reset.
// Expected bit streams are derived from the word constants below.
module tb_par_serializer_lanes;

   logic       clk = 1'b0;
   logic       reset_L;
   logic       v1, v2;
   logic [7:0] d1, d2;
   logic       r1, r2;
   logic [0:0] o1;
   logic [1:0] o2;
   logic       ws1, ws2, da1, da2, sd1, sd2;

   int checks = 0;
   int errors = 0;

   logic [7:0] idle = 8'hBC;
   logic [7:0] wa5  = 8'hA5;
   logic [7:0] waa  = 8'hAA;
   logic [7:0] w3c  = 8'h3C;
   logic [7:0] words [4] = '{8'h01, 8'h02, 8'h03, 8'h04};

   always #5 clk = ~clk;

   par_serializer_lanes #(
      .DATA_W(8), .LANES(1), .IDLE_WORD(8'hBC), .SYNC_WORDS(4)
   ) u1 (
      .clk(clk), .reset_L(reset_L), .valid_in(v1), .data_in(d1),
      .ready_out(r1), .data_out(o1), .word_start(ws1),
      .data_active(da1), .sync_done(sd1)
   );

   par_serializer_lanes #(
      .DATA_W(8), .LANES(2), .IDLE_WORD(8'hBC), .SYNC_WORDS(4)
   ) u2 (
      .clk(clk), .reset_L(reset_L), .valid_in(v2), .data_in(d2),
      .ready_out(r2), .data_out(o2), .word_start(ws2),
      .data_active(da2), .sync_done(sd2)
   );

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_dout"}, 8'(o1), 8'd1);
      chk({tag, "_ws"}, 8'(ws1), 8'd1);
      chk({tag, "_da"}, 8'(da1), 8'd0);
      chk({tag, "_rdy"}, 8'(r1), 8'd0);
      chk({tag, "_sd"}, 8'(sd1), 8'd0);
      chk({tag, "_dout2"}, 8'(o2), 8'h03);
      chk({tag, "_sd2"}, 8'(sd2), 8'd0);
   endtask

   // 32 idle bits, then sync_done and ready_out together.
   task automatic check_preamble(input int pulse_at);
      for (int i = 0; i < 32; i++) begin
         chk("pre_dout", 8'(o1), 8'(idle[7-(i%8)]));
         chk("pre_ws", 8'(ws1), 8'((i % 8) == 0));
         chk("pre_da", 8'(da1), 8'd0);
         chk("pre_rdy", 8'(r1), 8'd0);
         chk("pre_sd", 8'(sd1), 8'd0);
         v1 = (i == pulse_at);
         d1 = 8'hFF;
         step();
      end
      v1 = 1'b0;
      chk("sync_sd", 8'(sd1), 8'd1);
      chk("sync_rdy", 8'(r1), 8'd1);
      chk("sync_ws", 8'(ws1), 8'd1);
      chk("sync_da", 8'(da1), 8'd0);
      chk("sync_dout", 8'(o1), 8'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int  wi;
      int  n;
      logic exp_r;
      reset_L = 1'b0;
      v1 = 1'b0; d1 = 8'h00;
      v2 = 1'b0; d2 = 8'h00;
      repeat (2) step();
      chk_reset_vals("rst");
      reset_L = 1'b1;

      check_preamble(-1);

      v1 = 1'b1; d1 = wa5;
      step();
      v1 = 1'b0;
      for (int i = 1; i < 8; i++) begin
         chk("a5_idle", 8'(o1), 8'(idle[7-i]));
         chk("a5_idle_da", 8'(da1), 8'd0);
         step();
      end
      for (int i = 0; i < 8; i++) begin
         chk("a5_dout", 8'(o1), 8'(wa5[7-i]));
         chk("a5_da", 8'(da1), 8'd1);
         chk("a5_ws", 8'(ws1), 8'(i == 0));
         step();
      end
      chk("a5_post_da", 8'(da1), 8'd0);
      chk("a5_post_ws", 8'(ws1), 8'd1);
      chk("a5_post_dout", 8'(o1), 8'd1);

      wi = 0;
      for (int c = 0; c < 40; c++) begin
         exp_r = (c < 2) || (c == 8) || (c == 16);
         if (c <= 16) chk("b2b_rdy", 8'(r1), 8'(exp_r));
         if (c >= 8) begin
            chk("b2b_dout", 8'(o1), 8'(words[(c-8)/8][7-((c-8)%8)]));
            chk("b2b_da", 8'(da1), 8'd1);
         end else begin
            chk("b2b_idle", 8'(o1), 8'(idle[7-c]));
            chk("b2b_idle_da", 8'(da1), 8'd0);
         end
         v1 = (wi < 4);
         d1 = words[(wi < 4) ? wi : 0];
         step();
         if (exp_r && wi < 4) wi++;
      end
      v1 = 1'b0;
      chk("b2b_end_da", 8'(da1), 8'd0);
      chk("b2b_end_ws", 8'(ws1), 8'd1);

      v1 = 1'b1; d1 = waa;
      step();
      d1 = 8'hBB;
      step();
      v1 = 1'b0;
      repeat (6) step();
      v1 = 1'b1; d1 = 8'hCC;
      step();
      v1 = 1'b0;
      repeat (2) step();
      chk("mid_dout", 8'(o1), 8'(waa[4]));
      chk("mid_da", 8'(da1), 8'd1);
      reset_L = 1'b0;
      #1;
      chk_reset_vals("async");
      step();
      reset_L = 1'b1;

      check_preamble(5);
      for (int i = 0; i < 16; i++) begin
         chk("post_dout", 8'(o1), 8'(idle[7-(i%8)]));
         chk("post_da", 8'(da1), 8'd0);
         step();
      end

      n = 0;
      while (!ws2 && n < 8) begin
         step();
         n++;
      end
      chk("l2_align", 8'(ws2), 8'd1);
      chk("l2_rdy", 8'(r2), 8'd1);
      v2 = 1'b1; d2 = w3c;
      step();
      v2 = 1'b0;
      for (int i = 1; i < 4; i++) begin
         chk("l2_idle", 8'(o2), 8'({idle[7-i], idle[3-i]}));
         chk("l2_idle_ws", 8'(ws2), 8'd0);
         step();
      end
      for (int i = 0; i < 4; i++) begin
         chk("l2_dout", 8'(o2), 8'({w3c[7-i], w3c[3-i]}));
         chk("l2_ws", 8'(ws2), 8'(i == 0));
         chk("l2_da", 8'(da2), 8'd1);
         step();
      end
      chk("l2_post_dout", 8'(o2), 8'h03);
      chk("l2_post_ws", 8'(ws2), 8'd1);
      chk("l2_post_da", 8'(da2), 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
